// File: rtl/itcm_fetch_rsp_if.sv
// IFU <-> ITCM fetch channel: request (valid/ready/pc) and response (valid/ready/instr[/err]).
// The err wire exists only when ITCM_RSP_ERR_EN is defined.
interface itcm_fetch_rsp_if #(
   parameter int PC_SIZE    = 32,
   parameter int INSTR_SIZE = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [PC_SIZE-1:0]    req_pc;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [INSTR_SIZE-1:0] rsp_instr;
`ifdef ITCM_RSP_ERR_EN
   logic                  rsp_err;
`endif

   modport master (
      output req_valid, req_pc, rsp_ready,
`ifdef ITCM_RSP_ERR_EN
      input  rsp_err,
`endif
      input  req_ready, rsp_valid, rsp_instr
   );

   modport slave (
      input  req_valid, req_pc, rsp_ready,
`ifdef ITCM_RSP_ERR_EN
      output rsp_err,
`endif
      output req_ready, rsp_valid, rsp_instr
   );
endinterface

// File: rtl/itcm_fetch_rsp.sv
// ITCM fetch responder: one-cycle read latency into a two-slot (R0 output, R1 skid) response buffer.
// Optional macro ITCM_RSP_ERR_EN adds err reporting for out-of-range and misaligned fetches.
module itcm_fetch_rsp #(
   parameter int ITCM_DEPTH = 1024,
   parameter int AW         = 10,
   parameter int PC_SIZE    = 32,
   parameter int INSTR_SIZE = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   itcm_fetch_rsp_if.slave       ifu,
   input  logic                  ld_valid,
   input  logic [AW-1:0]         ld_addr,
   input  logic [INSTR_SIZE-1:0] ld_data
);
   localparam logic [INSTR_SIZE-1:0] NOP = INSTR_SIZE'(32'h0000_0013);

   logic [INSTR_SIZE-1:0] mem [0:ITCM_DEPTH-1];

   logic                  r0_v, r1_v, r0_v_nxt, r1_v_nxt;
   logic [INSTR_SIZE-1:0] r0_instr, r1_instr, r0_instr_nxt, r1_instr_nxt;
   logic [INSTR_SIZE-1:0] rd_instr;
   logic [AW-1:0]         rd_idx;
   logic                  in_range;
   logic                  acc, cons;
`ifdef ITCM_RSP_ERR_EN
   logic                  r0_err, r1_err, r0_err_nxt, r1_err_nxt;
   logic                  rd_err;
`else
   logic                  unused_pc_lsb;
   assign unused_pc_lsb = ^ifu.req_pc[1:0];
`endif

   assign rd_idx   = ifu.req_pc[AW+1:2];
   assign in_range = ~|ifu.req_pc[PC_SIZE-1:AW+2];

   // Read sees pre-edge contents, so a same-cycle load to the fetched word returns old data.
   always_comb begin
`ifdef ITCM_RSP_ERR_EN
      rd_err   = !in_range || (ifu.req_pc[1:0] != 2'b00);
      rd_instr = rd_err ? '0 : mem[rd_idx];
`else
      rd_instr = in_range ? mem[rd_idx] : NOP;
`endif
   end

   always_ff @(posedge clk) begin
      if (ld_valid) mem[ld_addr] <= ld_data;
   end

   assign ifu.req_ready = !r1_v;
   assign acc  = ifu.req_valid && !r1_v;
   assign cons = r0_v && ifu.rsp_ready;

   always_comb begin
      r0_v_nxt     = r0_v;
      r1_v_nxt     = r1_v;
      r0_instr_nxt = r0_instr;
      r1_instr_nxt = r1_instr;
`ifdef ITCM_RSP_ERR_EN
      r0_err_nxt   = r0_err;
      r1_err_nxt   = r1_err;
`endif
      if (r1_v && cons) begin
         r0_instr_nxt = r1_instr;
`ifdef ITCM_RSP_ERR_EN
         r0_err_nxt   = r1_err;
`endif
         r1_v_nxt     = 1'b0;
      end else if (acc && (!r0_v || cons)) begin
         r0_v_nxt     = 1'b1;
         r0_instr_nxt = rd_instr;
`ifdef ITCM_RSP_ERR_EN
         r0_err_nxt   = rd_err;
`endif
      end else if (acc) begin
         r1_v_nxt     = 1'b1;
         r1_instr_nxt = rd_instr;
`ifdef ITCM_RSP_ERR_EN
         r1_err_nxt   = rd_err;
`endif
      end else if (cons) begin
         r0_v_nxt     = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r0_v     <= 1'b0;
         r1_v     <= 1'b0;
         r0_instr <= '0;
         r1_instr <= '0;
`ifdef ITCM_RSP_ERR_EN
         r0_err   <= 1'b0;
         r1_err   <= 1'b0;
`endif
      end else begin
         r0_v     <= r0_v_nxt;
         r1_v     <= r1_v_nxt;
         r0_instr <= r0_instr_nxt;
         r1_instr <= r1_instr_nxt;
`ifdef ITCM_RSP_ERR_EN
         r0_err   <= r0_err_nxt;
         r1_err   <= r1_err_nxt;
`endif
      end
   end

   assign ifu.rsp_valid = r0_v;
   assign ifu.rsp_instr = r0_instr;
`ifdef ITCM_RSP_ERR_EN
   assign ifu.rsp_err   = r0_err;
`endif
endmodule

// File: tb/tb_itcm_fetch_rsp.sv
// Directed bench for itcm_fetch_rsp: vector table of single fetches plus hand sequences for stall, load race and reset.
module tb_itcm_fetch_rsp;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ld_valid = 1'b0;
   logic [9:0]  ld_addr = '0;
   logic [31:0] ld_data = '0;
   int          errors = 0;
   int          checks = 0;

   itcm_fetch_rsp_if #(.PC_SIZE(32), .INSTR_SIZE(32)) bus ();

   itcm_fetch_rsp #(.ITCM_DEPTH(1024), .AW(10), .PC_SIZE(32), .INSTR_SIZE(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .ifu      (bus.slave),
      .ld_valid (ld_valid),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] exp_instr;
      logic        exp_err;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [9:0] a, input logic [31:0] d);
      ld_valid = 1'b1; ld_addr = a; ld_data = d;
      tick();
      ld_valid = 1'b0;
   endtask

   vec_t vecs [8];
   logic [31:0] b2b [4];

   initial begin
      bus.req_valid = 1'b0;
      bus.req_pc    = '0;
      bus.rsp_ready = 1'b1;

      vecs[0] = '{32'h0000_0000, 32'h0000_1137, 1'b0};
      vecs[1] = '{32'h0000_0004, 32'h0000_0093, 1'b0};
      vecs[2] = '{32'h0000_0008, 32'h0010_0113, 1'b0};
      vecs[3] = '{32'h0000_000C, 32'h0020_81B3, 1'b0};
      vecs[4] = '{32'h0000_0FFC, 32'hCAFE_F00D, 1'b0};
`ifdef ITCM_RSP_ERR_EN
      vecs[5] = '{32'h0000_1000, 32'h0000_0000, 1'b1};
      vecs[6] = '{32'h0000_0002, 32'h0000_0000, 1'b1};
      vecs[7] = '{32'h8000_0000, 32'h0000_0000, 1'b1};
`else
      vecs[5] = '{32'h0000_1000, 32'h0000_0013, 1'b0};
      vecs[6] = '{32'h0000_0002, 32'h0000_1137, 1'b0};
      vecs[7] = '{32'h8000_0000, 32'h0000_0013, 1'b0};
`endif
      b2b[0] = 32'h0000_1137; b2b[1] = 32'h0000_0093;
      b2b[2] = 32'h0010_0113; b2b[3] = 32'h0020_81B3;

      #3;
      chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset req_ready", 32'(bus.req_ready), 32'd1);
      chk("reset rsp_instr", bus.rsp_instr, 32'd0);
`ifdef ITCM_RSP_ERR_EN
      chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
`endif
      tick();
      rst = 1'b0;

      load(10'd0, 32'h0000_1137);
      load(10'd1, 32'h0000_0093);
      load(10'd2, 32'h0010_0113);
      load(10'd3, 32'h0020_81B3);
      load(10'd1023, 32'hCAFE_F00D);

      // Single fetches, each drained before the next
      for (int i = 0; i < 8; i++) begin
         bus.req_valid = 1'b1;
         bus.req_pc    = vecs[i].pc;
         tick();
         bus.req_valid = 1'b0;
         chk($sformatf("vec%0d valid", i), 32'(bus.rsp_valid), 32'd1);
         chk($sformatf("vec%0d instr", i), bus.rsp_instr, vecs[i].exp_instr);
`ifdef ITCM_RSP_ERR_EN
         chk($sformatf("vec%0d err", i), 32'(bus.rsp_err), 32'(vecs[i].exp_err));
`endif
         tick();
         chk($sformatf("vec%0d drained", i), 32'(bus.rsp_valid), 32'd0);
      end

      // Back-to-back fetches: one response per cycle, one cycle after accept
      bus.req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.req_pc = 32'(i * 4);
         tick();
         chk($sformatf("b2b%0d instr", i), bus.rsp_instr, b2b[i]);
         chk($sformatf("b2b%0d ready", i), 32'(bus.req_ready), 32'd1);
      end
      bus.req_valid = 1'b0;
      tick();
      chk("b2b drained", 32'(bus.rsp_valid), 32'd0);

      // Stall: fill both slots, R0 held, then drain in order
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_pc    = 32'h0;
      tick();
      chk("stall1 req_ready", 32'(bus.req_ready), 32'd1);
      chk("stall1 instr", bus.rsp_instr, 32'h0000_1137);
      bus.req_pc = 32'h4;
      tick();
      bus.req_valid = 1'b0;
      chk("stall2 req_ready", 32'(bus.req_ready), 32'd0);
      chk("stall2 instr", bus.rsp_instr, 32'h0000_1137);
      tick();
      chk("stall hold valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall hold instr", bus.rsp_instr, 32'h0000_1137);
      chk("stall hold ready", 32'(bus.req_ready), 32'd0);
      bus.rsp_ready = 1'b1;
      tick();
      chk("drain instr", bus.rsp_instr, 32'h0000_0093);
      chk("drain valid", 32'(bus.rsp_valid), 32'd1);
      chk("drain req_ready", 32'(bus.req_ready), 32'd1);
      tick();
      chk("drain empty", 32'(bus.rsp_valid), 32'd0);

      // Same-cycle load and fetch of word 2
      ld_valid = 1'b1; ld_addr = 10'd2; ld_data = 32'hDEAD_BEEF;
      bus.req_valid = 1'b1; bus.req_pc = 32'h8;
      tick();
      ld_valid = 1'b0; bus.req_valid = 1'b0;
      chk("rbw old data", bus.rsp_instr, 32'h0010_0113);
      tick();
      bus.req_valid = 1'b1; bus.req_pc = 32'h8;
      tick();
      bus.req_valid = 1'b0;
      chk("rbw new data", bus.rsp_instr, 32'hDEAD_BEEF);
      tick();

      // Reset with both slots full
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b1; bus.req_pc = 32'h0;
      tick();
      bus.req_pc = 32'h4;
      tick();
      bus.req_valid = 1'b0;
      chk("full before rst", 32'(bus.req_ready), 32'd0);
      #2 rst = 1'b1;
      #1;
      chk("rst async valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst async ready", 32'(bus.req_ready), 32'd1);
      chk("rst async instr", bus.rsp_instr, 32'd0);
      tick();
      rst = 1'b0;
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b1; bus.req_pc = 32'h4;
      tick();
      bus.req_valid = 1'b0;
      chk("post rst valid", 32'(bus.rsp_valid), 32'd1);
      chk("post rst instr", bus.rsp_instr, 32'h0000_0093);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
